// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
// Holds FSM state encodings, port owner IDs and default parameter values.
package mem_port_arbiter_pkg;

    localparam int DEF_XLEN           = 32;
    localparam int DEF_MAX_D_STREAK   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    localparam int STREAK_W = 4;
    localparam int TIMER_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic owner_t owner_from_pick(input logic pick_d);
        return pick_d ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port seen by the arbiter.
// The slave modport is the arbiter's view; master is the CPU/LSU/memory environment.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);

    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_rdata;
    logic            i_ack;
    logic            i_err;

    logic            d_req;
    logic [XLEN-1:0] d_addr;
    logic            d_we;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;
    logic            d_ack;
    logic            d_err;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack, i_err,
        input  d_req, d_addr, d_we, d_wdata,
        output d_rdata, d_ack, d_err,
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack, i_err,
        output d_req, d_addr, d_we, d_wdata,
        input  d_rdata, d_ack, d_err,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter_arb_fair_select.sv
// Data-priority pick between I and D with a starvation guard: after MAX_D_STREAK
// consecutive D grants while I waits, the next grant goes to I.
module arb_fair_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
)(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic pick_d,
    output logic pick_valid
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
        return (v == '1) ? v : v + STREAK_W'(1);
    endfunction

    assign pick_valid = i_req | d_req;
    assign pick_d     = d_req && !(i_req && (streak == STREAK_MAX));

    // The streak only counts D wins that actually made I wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_en && pick_valid) begin
            if (pick_d && i_req) begin
                streak <= sat_inc(streak);
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between the fetch (I) and load/store (D) ports,
// with data priority, starvation guard and a per-access timeout returning an error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int MAX_D_STREAK   = DEF_MAX_D_STREAK,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    owner_t              owner;
    logic [TIMER_W-1:0]  timer;
    logic                grant_en;
    logic                pick_d;
    logic                pick_valid;
    logic [XLEN-1:0]     resp_rdata;

    assign grant_en = (state == S_IDLE);

    arb_fair_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_fair_select (
        .clk        (clk),
        .rst        (rst),
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .grant_en   (grant_en),
        .pick_d     (pick_d),
        .pick_valid (pick_valid)
    );

    // Writes and timeouts return zero data; only an acked read carries memory data.
    assign resp_rdata = (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            owner         <= OWN_I;
            timer         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.i_ack     <= 1'b0;
            bus.i_err     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            // Response outputs are single-cycle and read as zero whenever ack is low.
            bus.i_ack   <= 1'b0;
            bus.i_err   <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_ack   <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= '0;

            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner         <= owner_from_pick(pick_d);
                        bus.mem_addr  <= pick_d ? bus.d_addr : bus.i_addr;
                        bus.mem_we    <= pick_d && bus.d_we;
                        bus.mem_wdata <= pick_d ? bus.d_wdata : '0;
                        bus.mem_req   <= 1'b1;
                        timer         <= '0;
                        state         <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // An ack arriving on the last timer cycle still counts as success.
                    if (bus.mem_ack || (timer == TIMER_LAST)) begin
                        bus.mem_req <= 1'b0;
                        state       <= S_RESP;
                        if (owner == OWN_D) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_err   <= !bus.mem_ack;
                            bus.d_rdata <= resp_rdata;
                        end else begin
                            bus.i_ack   <= 1'b1;
                            bus.i_err   <= !bus.mem_ack;
                            bus.i_rdata <= resp_rdata;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state       <= S_IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference:
// a reference memory, a grant-order model and latency/timeout expectations.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(
        .XLEN           (32),
        .MAX_D_STREAK   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem_arr [16];
    logic [31:0] ref_mem [16];

    bit auto_mem;
    bit rand_delay;
    int ack_delay;
    int issue_cnt;

    // Advance one clock and play the memory side for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (bus.mem_req) begin
                bus.mem_ack   = (ack_delay >= 0) && (issue_cnt == ack_delay);
                bus.mem_rdata = bus.mem_ack ? mem_arr[bus.mem_addr[3:0]] : $urandom;
                if (bus.mem_ack && bus.mem_we) mem_arr[bus.mem_addr[3:0]] = bus.mem_wdata;
                issue_cnt++;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                issue_cnt     = 0;
                if (rand_delay) ack_delay = $urandom_range(0, 3);
            end
        end
    endtask

    task automatic clear_reqs();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got [10];
        string       nm  [10];
        clear_reqs();
        auto_mem = 1'b0;
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        got[0] = 32'(bus.mem_req);  nm[0] = "rst_mem_req";
        got[1] = bus.mem_addr;      nm[1] = "rst_mem_addr";
        got[2] = 32'(bus.mem_we);   nm[2] = "rst_mem_we";
        got[3] = bus.mem_wdata;     nm[3] = "rst_mem_wdata";
        got[4] = 32'(bus.i_ack);    nm[4] = "rst_i_ack";
        got[5] = 32'(bus.i_err);    nm[5] = "rst_i_err";
        got[6] = bus.i_rdata;       nm[6] = "rst_i_rdata";
        got[7] = 32'(bus.d_ack);    nm[7] = "rst_d_ack";
        got[8] = 32'(bus.d_err);    nm[8] = "rst_d_err";
        got[9] = bus.d_rdata;       nm[9] = "rst_d_rdata";
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (got[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL %s: got %h expected 0", nm[k], got[k]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read(input int addr, input logic [31:0] val, input string tag);
        int lat;
        bit seen_d;
        bit first_ok;
        auto_mem = 1'b1; rand_delay = 1'b0; ack_delay = 0;
        mem_arr[addr[3:0]] = val;
        ref_mem[addr[3:0]] = val;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'(addr);
        lat = 0; seen_d = 1'b0; first_ok = 1'b0;
        do begin
            step();
            lat++;
            if (lat == 1) first_ok = bus.mem_req && (bus.mem_addr == 32'(addr)) && !bus.mem_we;
            if (bus.d_ack) seen_d = 1'b1;
        end while (!bus.i_ack && lat < 10);
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("FAIL %s_latency: got %0d expected 2", tag, lat); end
        n_cmp++;
        if (first_ok !== 1'b1) begin n_fail++; $display("FAIL %s_issue: mem_req/addr/we wrong in first cycle (got %0b expected 1)", tag, first_ok); end
        n_cmp++;
        if (bus.i_rdata !== val) begin n_fail++; $display("FAIL %s_rdata: got %h expected %h", tag, bus.i_rdata, val); end
        n_cmp++;
        if (bus.i_err !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b expected 0", tag, bus.i_err); end
        bus.i_req = 1'b0;
        repeat (3) begin step(); if (bus.d_ack) seen_d = 1'b1; end
        n_cmp++;
        if (seen_d !== 1'b0) begin n_fail++; $display("FAIL %s_no_d_ack: got %b expected 0", tag, seen_d); end
    endtask

    task automatic test_write();
        int  issue_cycles = 0;
        int  cyc = 0;
        bit  bus_ok = 1'b1;
        auto_mem = 1'b1; rand_delay = 1'b0; ack_delay = 3;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEADBEEF;
        do begin
            step();
            cyc++;
            if (bus.mem_req) begin
                issue_cycles++;
                if (!bus.mem_we || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_addr !== 32'h40) bus_ok = 1'b0;
            end
        end while (!bus.d_ack && cyc < 20);
        n_cmp++;
        if (bus_ok !== 1'b1) begin n_fail++; $display("FAIL wr_bus: got %b expected 1 (mem_we/mem_wdata/mem_addr stable)", bus_ok); end
        n_cmp++;
        if (issue_cycles !== 4) begin n_fail++; $display("FAIL wr_issue_len: got %0d expected 4", issue_cycles); end
        n_cmp++;
        if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0 || bus.i_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_resp: got ack=%b rdata=%h err=%b i_ack=%b expected 1/0/0/0", bus.d_ack, bus.d_rdata, bus.d_err, bus.i_ack);
        end
        ref_mem[0] = 32'hDEADBEEF;
        clear_reqs();
        repeat (2) step();
    endtask

    task automatic test_timeout(input int delay, input int addr, input string tag);
        int  req_cycles = 0;
        int  cyc = 0;
        bit  exp_err;
        logic [31:0] exp_data;
        auto_mem = 1'b1; rand_delay = 1'b0; ack_delay = delay;
        exp_err  = (delay < 0);
        exp_data = exp_err ? 32'h0 : ref_mem[addr[3:0]];
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'(addr);
        do begin
            step();
            cyc++;
            if (bus.mem_req) req_cycles++;
        end while (!bus.d_ack && cyc < 30);
        n_cmp++;
        if (req_cycles !== 8) begin n_fail++; $display("FAIL %s_req_cycles: got %0d expected 8", tag, req_cycles); end
        n_cmp++;
        if (bus.d_ack !== 1'b1 || bus.d_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err: got ack=%b err=%b expected 1/%b", tag, bus.d_ack, bus.d_err, exp_err);
        end
        n_cmp++;
        if (bus.d_rdata !== exp_data) begin n_fail++; $display("FAIL %s_rdata: got %h expected %h", tag, bus.d_rdata, exp_data); end
        clear_reqs();
        repeat (2) step();
    endtask

    task automatic test_reset_abort();
        bit quiet = 1'b1;
        auto_mem = 1'b0; bus.mem_ack = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h3;
        step();
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL abort_issue: got mem_req=%b expected 1", bus.mem_req); end
        bus.i_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_mem_req: got %b expected 0", bus.mem_req); end
        repeat (4) begin
            step();
            bus.mem_ack = 1'b0;
            if (bus.i_ack || bus.d_ack || bus.mem_req) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL abort_quiet: got %b expected 1 (no ack, no mem_req)", quiet); end
    endtask

    task automatic test_spurious_ack();
        bit quiet = 1'b1;
        auto_mem = 1'b0;
        clear_reqs();
        repeat (6) begin
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            step();
            if (bus.mem_req || bus.i_ack || bus.d_ack || bus.i_err || bus.d_err ||
                bus.i_rdata != 0 || bus.d_rdata != 0) quiet = 1'b0;
        end
        bus.mem_ack = 1'b0;
        n_cmp++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL spurious_quiet: got %b expected 1", quiet); end
        test_single_read(11, 32'h0BADF00D, "post_spurious");
    endtask

    task automatic test_back_to_back_fairness();
        int d_run = 0;
        int done  = 0;
        int cyc   = 0;
        bit exp_d;
        logic [31:0] exp_v;
        do_reset();
        auto_mem = 1'b1; rand_delay = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = $urandom;
        bus.d_req = 1'b1; bus.d_addr = $urandom; bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom;
        while (done < 10 && cyc < 300) begin
            step();
            cyc++;
            if (bus.i_ack || bus.d_ack) begin
                // Both ports always pending: D wins until it has won MAX_D_STREAK times in a row.
                exp_d = (d_run != 4);
                d_run = exp_d ? d_run + 1 : 0;
                n_cmp++;
                if (bus.d_ack !== exp_d || (bus.i_ack && bus.d_ack)) begin
                    n_fail++;
                    $display("FAIL grant_order[%0d]: got i_ack=%b d_ack=%b expected %s", done, bus.i_ack, bus.d_ack, exp_d ? "D" : "I");
                end
                if (bus.i_ack) begin
                    exp_v = ref_mem[bus.i_addr[3:0]];
                    n_cmp++;
                    if (bus.i_rdata !== exp_v || bus.i_err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_i_data[%0d]: got %h err=%b expected %h", done, bus.i_rdata, bus.i_err, exp_v);
                    end
                    bus.i_addr = $urandom;
                end
                if (bus.d_ack) begin
                    exp_v = bus.d_we ? 32'h0 : ref_mem[bus.d_addr[3:0]];
                    n_cmp++;
                    if (bus.d_rdata !== exp_v || bus.d_err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_d_data[%0d]: got %h err=%b expected %h", done, bus.d_rdata, bus.d_err, exp_v);
                    end
                    if (bus.d_we) ref_mem[bus.d_addr[3:0]] = bus.d_wdata;
                    bus.d_addr = $urandom; bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom;
                end
                done++;
            end
        end
        n_cmp++;
        if (done !== 10) begin n_fail++; $display("FAIL b2b_done: got %0d expected 10", done); end
        clear_reqs();
        repeat (3) step();
    endtask

    task automatic test_random_traffic();
        int done = 0, cyc = 0, i_wait = 0, d_wait = 0, max_wait = 0, bad = 0;
        logic [31:0] exp_v;
        auto_mem = 1'b1; rand_delay = 1'b1;
        while (done < 80 && cyc < 4000) begin
            if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                bus.i_req = 1'b1; bus.i_addr = $urandom; i_wait = 0;
            end
            if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b1; bus.d_addr = $urandom; bus.d_we = 1'($urandom_range(0, 1));
                bus.d_wdata = $urandom; d_wait = 0;
            end
            step();
            cyc++;
            if (bus.i_req) i_wait++;
            if (bus.d_req) d_wait++;
            if (i_wait > max_wait) max_wait = i_wait;
            if (d_wait > max_wait) max_wait = d_wait;
            if ((bus.i_ack && !bus.i_req) || (bus.d_ack && !bus.d_req) || (bus.i_ack && bus.d_ack)) bad++;
            if (bus.i_ack) begin
                exp_v = ref_mem[bus.i_addr[3:0]];
                n_cmp++;
                if (bus.i_rdata !== exp_v || bus.i_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_i_data[%0d]: got %h err=%b expected %h", done, bus.i_rdata, bus.i_err, exp_v);
                end
                bus.i_req = 1'b0; done++;
            end
            if (bus.d_ack) begin
                exp_v = bus.d_we ? 32'h0 : ref_mem[bus.d_addr[3:0]];
                n_cmp++;
                if (bus.d_rdata !== exp_v || bus.d_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_d_data[%0d]: got %h err=%b expected %h", done, bus.d_rdata, bus.d_err, exp_v);
                end
                if (bus.d_we) ref_mem[bus.d_addr[3:0]] = bus.d_wdata;
                bus.d_req = 1'b0; done++;
            end
        end
        n_cmp++;
        if (done < 80) begin n_fail++; $display("FAIL rnd_progress: got %0d completions expected 80", done); end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL rnd_ack_owner: got %0d bad acks expected 0", bad); end
        n_cmp++;
        if (max_wait > 40) begin n_fail++; $display("FAIL rnd_starvation: got max wait %0d expected <= 40", max_wait); end
        clear_reqs();
        repeat (3) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        auto_mem = 1'b0; rand_delay = 1'b0; ack_delay = 0; issue_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            mem_arr[k] = $urandom;
            ref_mem[k] = mem_arr[k];
        end

        test_reset();
        test_single_read(5, 32'h00000013, "single_read");
        test_write();
        test_timeout(-1, 7, "timeout");
        test_timeout(7, 9, "ack_last_cycle");
        test_back_to_back_fairness();
        test_random_traffic();
        test_reset_abort();
        test_spurious_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
